// File: rtl/wb_store_issuer.sv
// Store issuer: in-order FIFO from writeback to the dcache WBAQ; optional WB_STORE_BYPASS_EN gives empty-FIFO bypass.
// Latency: 1 cycle st_* -> wb_* (0 cycles on bypass when WB_STORE_BYPASS_EN is defined).
// Backpressure: holds wb_* while wbaq_isfull; raises st_stall when full and no pop this cycle.
module wb_store_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    st_valid,
    input  logic [31:0]             st_addr,
    input  logic [63:0]             st_data,
    input  logic [1:0]              st_size,
    input  logic [6:0]              st_ptcid,
    output logic                    st_stall,
    output logic                    wb_valid,
    output logic [31:0]             wb_memaddr,
    output logic [63:0]             wb_memdata,
    output logic [1:0]              wb_size,
    output logic [6:0]              wb_ptcid,
    input  logic                    wbaq_isfull,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [6:0]  ptcid;
    } st_entry_t;

    st_entry_t      mem [DEPTH];
    st_entry_t      in_ent;
    st_entry_t      out_ent;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           fifo_push;
    logic           fifo_pop;

    // The dcache relies on bytes above the store size being zero.
    always_comb begin
        in_ent       = '0;
        in_ent.addr  = st_addr;
        in_ent.size  = st_size;
        in_ent.ptcid = st_ptcid;
        case (st_size)
            2'b00:   in_ent.data = {56'd0, st_data[7:0]};
            2'b01:   in_ent.data = {48'd0, st_data[15:0]};
            2'b10:   in_ent.data = {32'd0, st_data[31:0]};
            default: in_ent.data = st_data;
        endcase
    end

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

`ifdef WB_STORE_BYPASS_EN
    assign bypass = fifo_empty & st_valid & ~wbaq_isfull;
`else
    assign bypass = 1'b0;
`endif

    assign wb_valid  = ~fifo_empty | bypass;
    assign pop       = wb_valid & ~wbaq_isfull;
    assign st_stall  = st_valid & fifo_full & ~pop;
    assign push      = st_valid & ~st_stall;
    // A bypassed store is both accepted and delivered without touching storage.
    assign fifo_push = push & ~bypass;
    assign fifo_pop  = pop & ~bypass;

    always_comb begin
        out_ent = '0;
        if (bypass)
            out_ent = in_ent;
        else if (!fifo_empty)
            out_ent = mem[head];
    end

    assign wb_memaddr = out_ent.addr;
    assign wb_memdata = out_ent.data;
    assign wb_size    = out_ent.size;
    assign wb_ptcid   = out_ent.ptcid;
    assign occupancy  = count;
    assign empty      = fifo_empty;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fifo_push)
                tail <= tail + 1'b1;
            if (fifo_pop)
                head <= head + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by count, and a full-FIFO
    // re-push into the head slot only becomes visible after head advances.
    always_ff @(posedge clk) begin
        if (fifo_push)
            mem[tail] <= in_ent;
    end

endmodule

// File: tb/tb_wb_store_issuer.sv
// Bench for wb_store_issuer: table vectors, hand-written corner sequences and an in-order scoreboard.
module tb_wb_store_issuer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [6:0]  ptcid;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic [6:0]  st_ptcid;
    logic        st_stall;
    logic        wb_valid;
    logic [31:0] wb_memaddr;
    logic [63:0] wb_memdata;
    logic [1:0]  wb_size;
    logic [6:0]  wb_ptcid;
    logic        wbaq_isfull;
    logic [$clog2(DEPTH):0] occupancy;
    logic        empty;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    bit   rand_en  = 1'b0;

    always #5 clk = ~clk;

    wb_store_issuer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_size    (st_size),
        .st_ptcid   (st_ptcid),
        .st_stall   (st_stall),
        .wb_valid   (wb_valid),
        .wb_memaddr (wb_memaddr),
        .wb_memdata (wb_memdata),
        .wb_size    (wb_size),
        .wb_ptcid   (wb_ptcid),
        .wbaq_isfull(wbaq_isfull),
        .occupancy  (occupancy),
        .empty      (empty)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s,
                                input logic [6:0] p, input logic [63:0] e);
        vec_t v;
        v.addr = a; v.data = d; v.size = s; v.ptcid = p; v.exp = e;
        return v;
    endfunction

    function automatic logic [63:0] ref_mask(input logic [63:0] d, input logic [1:0] s);
        int nbits;
        nbits = 8 << s;
        if (nbits >= 64)
            return d;
        return d & ((64'd1 << nbits) - 64'd1);
    endfunction

    // Drives a store and records what the dcache side must later see.
    task automatic put(input vec_t v);
        st_valid = 1'b1;
        st_addr  = v.addr;
        st_data  = v.data;
        st_size  = v.size;
        st_ptcid = v.ptcid;
        exp_q.push_back(v);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit acc;
        acc = 1'b0;
        put(v);
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = !st_stall;
            @(posedge clk);
            #1;
        end
        check("send_accept", 64'(acc), 64'd1);
        st_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0)
                break;
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a transfer completes at the coming edge when valid and not full.
    always @(negedge clk) begin
        vec_t e;
        if (clr && wb_valid && !wbaq_isfull) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: got store addr 0x%0h, expected no store", wb_memaddr);
            end else begin
                e = exp_q.pop_front();
                n_pops++;
                check("mon_addr",  64'(wb_memaddr), 64'(e.addr));
                check("mon_data",  wb_memdata,      e.exp);
                check("mon_size",  64'(wb_size),    64'(e.size));
                check("mon_ptcid", 64'(wb_ptcid),   64'(e.ptcid));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            wbaq_isfull = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v1;
        vec_t fill [DEPTH+1];
        vec_t tbl  [8];
        vec_t v;
        int   pops0;

        tbl[0] = mk(32'h0000_3000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 7'h01, 64'h0000_0000_0000_00FF);
        tbl[1] = mk(32'h0000_3004, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 7'h02, 64'h0000_0000_0000_FFFF);
        tbl[2] = mk(32'h0000_3008, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 7'h03, 64'h0000_0000_FFFF_FFFF);
        tbl[3] = mk(32'h0000_3010, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 7'h04, 64'hFFFF_FFFF_FFFF_FFFF);
        tbl[4] = mk(32'hFFFF_FFFF, 64'h1122_3344_5566_7788, 2'b00, 7'h7F, 64'h0000_0000_0000_0088);
        tbl[5] = mk(32'h8000_0001, 64'h1122_3344_5566_7788, 2'b01, 7'h40, 64'h0000_0000_0000_7788);
        tbl[6] = mk(32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 7'h2A, 64'h0000_0000_CAFE_F00D);
        tbl[7] = mk(32'h0000_0000, 64'hDEAD_BEEF_CAFE_F00D, 2'b11, 7'h00, 64'hDEAD_BEEF_CAFE_F00D);
        v1 = mk(32'h0000_1000, 64'h1122_3344_5566_7788, 2'b10, 7'h05, 64'h0000_0000_5566_7788);
        for (int i = 0; i <= DEPTH; i++)
            fill[i] = mk(32'h2000 + 32'(i * 8), {32'hA5A5_0000, 32'(i)}, 2'b11, 7'(i + 1),
                         {32'hA5A5_0000, 32'(i)});

        // Reset state
        clr = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; st_ptcid = '0;
        wbaq_isfull = 1'b0;
        #3;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_stall", 64'(st_stall), 64'd0);
        check("rst_addr", 64'(wb_memaddr), 64'd0);
        check("rst_data", wb_memdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        // Single store latency
        @(posedge clk); #1;
        put(v1);
`ifdef WB_STORE_BYPASS_EN
        @(negedge clk);
        check("byp_valid", 64'(wb_valid), 64'd1);
        check("byp_occ", 64'(occupancy), 64'd0);
        check("byp_data", wb_memdata, v1.exp);
        @(posedge clk); #1;
        st_valid = 1'b0;
`else
        @(negedge clk);
        check("lat_early_valid", 64'(wb_valid), 64'd0);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        check("lat_valid", 64'(wb_valid), 64'd1);
        check("lat_data", wb_memdata, v1.exp);
        check("lat_size", 64'(wb_size), 64'd2);
        check("lat_ptcid", 64'(wb_ptcid), 64'h05);
        @(posedge clk); #1;
`endif
        @(negedge clk);
        check("after_valid", 64'(wb_valid), 64'd0);
        check("after_empty", 64'(empty), 64'd1);
        drain();

        // Fill while dcache is full, one extra store stalls
        wbaq_isfull = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            put(fill[i]);
            @(negedge clk);
            check("fill_stall", 64'(st_stall), 64'd0);
            @(posedge clk); #1;
        end
        put(fill[DEPTH]);
        @(negedge clk);
        check("full_stall", 64'(st_stall), 64'd1);
        check("full_occ", 64'(occupancy), 64'(DEPTH));
        check("full_addr", 64'(wb_memaddr), 64'(fill[0].addr));
        check("full_data", wb_memdata, fill[0].exp);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_stall", 64'(st_stall), 64'd1);
        check("hold_addr", 64'(wb_memaddr), 64'(fill[0].addr));
        check("hold_ptcid", 64'(wb_ptcid), 64'(fill[0].ptcid));
        check("hold_occ", 64'(occupancy), 64'(DEPTH));

        // Release: same-cycle push and pop into a full FIFO
        @(posedge clk); #1;
        wbaq_isfull = 1'b0;
        @(negedge clk);
        check("unfull_stall", 64'(st_stall), 64'd0);
        check("unfull_occ", 64'(occupancy), 64'(DEPTH));
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        check("pushpop_occ", 64'(occupancy), 64'(DEPTH));
        drain();
        check("drained_empty", 64'(empty), 64'd1);

        // Table vectors back to back, dcache always ready
        pops0 = n_pops;
        for (int i = 0; i < 8; i++)
            send(tbl[i]);
        drain();
        check("tbl_pops", 64'(n_pops - pops0), 64'd8);

        // Random dcache backpressure
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v.addr  = $urandom;
            v.data  = {$urandom, $urandom};
            v.size  = 2'($urandom_range(0, 3));
            v.ptcid = 7'($urandom_range(0, 127));
            v.exp   = ref_mask(v.data, v.size);
            send(v);
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        wbaq_isfull = 1'b0;
        drain();

        // Asynchronous reset with three stores queued
        wbaq_isfull = 1'b1;
        for (int i = 0; i < 3; i++)
            send(tbl[i + 4]);
        @(negedge clk);
        check("pre_rst_occ", 64'(occupancy), 64'd3);
        check("pre_rst_valid", 64'(wb_valid), 64'd1);
        #2 clr = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_occ", 64'(occupancy), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_addr", 64'(wb_memaddr), 64'd0);
        check("arst_data", wb_memdata, 64'd0);
        check("arst_size", 64'(wb_size), 64'd0);
        check("arst_ptcid", 64'(wb_ptcid), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        clr = 1'b1;
        wbaq_isfull = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 64'(empty), 64'd1);
        check("post_rst_valid", 64'(wb_valid), 64'd0);
        @(posedge clk); #1;
        send(v1);
        drain();
        check("final_empty", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
